// File: rtl/voice_mixer_if.sv
// Frame-level bus between the mixer and its driver: sample strobe, voice
// inputs and controls in; mixed sample, valid, busy and overrun flags out.
interface voice_mixer_if #(
    parameter int NUM_VOICES = 16,
    parameter int WAVE_W     = 16,
    parameter int OUT_W      = 20
);
    logic                         sample_tick;
    logic [NUM_VOICES*WAVE_W-1:0] waves;
    logic [NUM_VOICES-1:0]        voice_en;
    logic [3:0]                   atten;
    logic signed [OUT_W-1:0]      signal;
    logic                         signal_valid;
    logic                         busy;
    logic                         overrun;

    modport master (
        output sample_tick, waves, voice_en, atten,
        input  signal, signal_valid, busy, overrun
    );

    modport slave (
        input  sample_tick, waves, voice_en, atten,
        output signal, signal_valid, busy, overrun
    );
endinterface

// File: rtl/voice_mixer.sv
// Time-multiplexed voice mixer: on each sample tick it snapshots all voices and
// adds one enabled voice per cycle, then publishes the attenuated sum.
module voice_mixer #(
    parameter int NUM_VOICES = 16,
    parameter int WAVE_W     = 16,
    parameter int OUT_W      = 20
) (
    input logic          clock,
    input logic          reset,
    voice_mixer_if.slave bus
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                       state;
    logic [NUM_VOICES*WAVE_W-1:0] snap_waves;
    logic [NUM_VOICES-1:0]        snap_en;
    logic [3:0]                   snap_atten;
    logic signed [OUT_W-1:0]      acc;
    logic [IDX_W-1:0]             index;
    logic signed [OUT_W-1:0]      signal_r;
    logic                         valid_r;
    logic                         busy_r;
    logic                         overrun_r;

    logic signed [WAVE_W-1:0]     cur_sample;
    logic signed [OUT_W-1:0]      cur_term;
    logic signed [OUT_W-1:0]      acc_next;

    always_comb begin
        cur_sample = snap_waves[index*WAVE_W +: WAVE_W];
        cur_term   = '0;
        if (snap_en[index]) begin
            cur_term = {{(OUT_W-WAVE_W){cur_sample[WAVE_W-1]}}, cur_sample};
        end
        acc_next = acc + cur_term;
    end

    // The last voice is folded straight into the published result, so the
    // DONE cycle is the one in which the new sample and its valid are visible.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            snap_waves <= '0;
            snap_en    <= '0;
            snap_atten <= '0;
            acc        <= '0;
            index      <= '0;
            signal_r   <= '0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sample_tick) begin
                        snap_waves <= bus.waves;
                        snap_en    <= bus.voice_en;
                        snap_atten <= bus.atten;
                        acc        <= '0;
                        index      <= '0;
                        busy_r     <= 1'b1;
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    overrun_r <= bus.sample_tick;
                    acc       <= acc_next;
                    index     <= index + 1'b1;
                    if (index == LAST_IDX) begin
                        signal_r <= acc_next >>> snap_atten;
                        valid_r  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    overrun_r <= bus.sample_tick;
                    busy_r    <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.signal       = signal_r;
    assign bus.signal_valid = valid_r;
    assign bus.busy         = busy_r;
    assign bus.overrun      = overrun_r;
endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
- Time-multiplexed 16-voice mixer directly downstream of the 16 oscillator instances; sums their signed 16-bit wave samples into one 20-bit mix sample per audio frame.
- Runs on the fast system clock and is triggered once per audio frame by a sample strobe.
- Result feeds the audio codec / DAC serialiser.
- Adds per-voice enable, master attenuation, and a valid strobe plus overrun flag.

Parameters:
NUM_VOICES, 16, number of voice inputs summed per frame
WAVE_W, 16, width of each signed voice sample
OUT_W, 20, width of signed mix output; must be >= WAVE_W + clog2(NUM_VOICES)

Ports:
clock  input  1  system clock, >= (NUM_VOICES+2) x 48 kHz
reset  input  1  asynchronous, active-low reset
sample_tick  input  1  one-cycle strobe at 48 kHz starting a frame
waves  input  NUM_VOICES*WAVE_W  packed signed samples; voice1 at [15:0], voice16 at [255:240]
voice_en  input  NUM_VOICES  bit i=1 includes voice i+1 in the sum
atten  input  4  master attenuation, arithmetic right shift applied to the final sum
signal  output  OUT_W  signed mixed sample, held between frames
signal_valid  output  1  one-cycle pulse when signal updates
busy  output  1  high while a frame is in progress
overrun  output  1  one-cycle pulse when sample_tick arrives while busy

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, accumulator=0, index=0, signal=0, signal_valid=0, busy=0, overrun=0. Reset mid-frame aborts the frame; no valid pulse follows.
- States: IDLE, ACCUM, DONE.
- IDLE: on sample_tick, snapshot waves, voice_en and atten into internal registers; clear accumulator; index=0; go to ACCUM. busy rises the cycle after the tick.
- ACCUM: one voice per cycle. If the snapshot enable bit for voice[index] is set, add its sign-extended sample to the accumulator; otherwise add 0. index increments 0..NUM_VOICES-1. After index NUM_VOICES-1 is added, go to DONE.
- DONE: signal <= accumulator >>> atten (arithmetic shift, sign preserved). signal_valid=1 for exactly this cycle. Return to IDLE.
- Latency: sample_tick sampled in cycle T; signal and signal_valid update in cycle T+NUM_VOICES+1, which is T+17 at the defaults.
- busy is high from T+1 through T+17 inclusive.
- Arithmetic:
  - Accumulator is OUT_W signed; no saturation is needed because the width rule guarantees no overflow.
  - Full-scale range at the defaults is -524288 to +524272.
  - atten values above 15 are impossible; atten=0 means pass-through.
- Input changes on waves, voice_en and atten after the snapshot do not affect the frame in progress.
- sample_tick while busy (including in the DONE cycle):
  - The tick is ignored and the frame in progress completes normally.
  - overrun pulses high for one cycle, the cycle after the offending tick.
- sample_tick in the same cycle the FSM returns to IDLE (the cycle after DONE) is accepted normally.
- signal holds its last value until the next DONE; it is never cleared except by reset.

Test Plan:
1. All voices = 16'h7FFF, voice_en=16'hFFFF, atten=0, one tick -> exactly 17 cycles later signal=20'h7FFF0 (524272), single valid pulse, busy high 17 cycles.
2. All voices = 16'h8000, voice_en=16'hFFFF, atten=0 -> signal=20'h80000 (-524288). Repeat with atten=4 -> signal=-32768 (20'hF8000).
3. voice1=100, voice2=-300, voice16=1000, others 5, voice_en=16'h8003 -> signal=800. Then voice_en=0 -> signal=0 with valid still pulsing.
4. Change waves and voice_en to all zeros at T+5 of a frame whose snapshot sum is 1234 -> signal=1234, and the new inputs are used only by the next tick.
5. Second sample_tick at T+8 -> overrun pulse at T+9, single valid at T+17 with the correct result. A tick at T+18 is accepted with no overrun.
6. Assert reset low at T+10 mid-frame -> signal=0, busy=0 immediately. No valid pulse. After release, the next tick produces a correct result 17 cycles later.
